spi_cfg_master: RTL and testbench
=================================

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 4..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: minimum NCS-high clk cycles between frames, legal range 1..255.
REQ-003 SHALL have parameter MAX_ADDR, default 7'h04: highest valid register address.
REQ-004 SHALL have ports as follows:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  2  per-requester write request.
- req_addr  in  14  {addr1[6:0], addr0[6:0]} register addresses.
- req_data  in  16  {data1[7:0], data0[7:0]} write data.
- req_ready  out  2  per-requester accept strobe.
- sclk  out  1  SPI serial clock, mode 0.
- ncs  out  1  SPI chip select, active-low.
- copi  out  1  SPI serial data out.
- busy  out  1  high from grant until the GAP state ends.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse when an address is rejected.

Function
REQ-005 SHALL implement the FSM states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-006 In IDLE with any req_valid high, SHALL grant exactly one requester, pulse its req_ready for one cycle, latch frame {1'b1, addr, data}, and enter SETUP on the next cycle.
REQ-007 Handshake: a transfer occurs when req_valid and req_ready are both high; a requester SHALL hold its valid and payload stable until ready; req_ready SHALL only assert in IDLE.
REQ-008 Arbitration SHALL be round-robin.
- Priority pointer resets to requester 0.
- After each grant, the pointer moves to the other requester.
- With a single request pending, that requester is granted regardless of the pointer.
REQ-009 SETUP SHALL:
- drive ncs=0, sclk=0 and copi=frame[15];
- last CLK_DIV cycles;
- then enter SHIFT.
REQ-010 SHIFT SHALL:
- drive sclk high for CLK_DIV cycles, then low for CLK_DIV cycles;
- generate exactly 16 rising edges, sending bits MSB first;
- update copi to the next bit on the cycle sclk falls;
- never change copi while sclk is high.
REQ-011 After the 16th high phase, SHALL enter HOLD: sclk=0, ncs=0 for CLK_DIV cycles.
REQ-012 HOLD SHALL then raise ncs, pulse done for one cycle, and enter GAP.
REQ-013 GAP SHALL hold ncs=1, sclk=0 for GAP_CYCLES cycles, then return to IDLE; busy SHALL deassert on return to IDLE.
REQ-014 ncs SHALL be low for exactly 34*CLK_DIV cycles per frame (136 at default).
REQ-015 Requests arriving while busy SHALL be ignored until IDLE; no request SHALL be lost if its valid is held.
REQ-016 The bit counter SHALL be 5 bits wide and SHALL not wrap within a frame; the divider counter SHALL be 8 bits wide.
REQ-017 ncs SHALL never be low outside SETUP, SHIFT and HOLD.

Reset
REQ-018 On rst_n=0 at a clk edge, SHALL force IDLE and the outputs sclk=0, ncs=1, copi=0, req_ready=0, busy=0, done=0, err=0, and pointer=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame at the next edge with ncs=1, and SHALL not pulse done.

Configuration
REQ-020 With macro SPI_CFG_ADDR_CHECK_EN defined, a granted request with addr>MAX_ADDR SHALL:
- still pulse req_ready;
- pulse err for one cycle on the next cycle;
- produce no frame (ncs stays 1);
- stay in IDLE and still advance the pointer.
REQ-021 Without SPI_CFG_ADDR_CHECK_EN, SHALL transmit all addresses, and err SHALL be tied to 0.

Verification
REQ-022 Bench: req0 addr=7'h00, data=8'hA5, default params -> one frame, bits 1000_0000_1010_0101 sampled at sclk rising edges, ncs low 136 cycles, done once.
REQ-023 Bench: req0 and req1 both valid from reset (addr 7'h02/8'h0F, 7'h04/8'h80) -> req0 framed first, then req1; GAP≥4 cycles ncs high between frames.
REQ-024 Bench: req1 held valid continuously, req0 pulsed each IDLE -> grants alternate 0,1,0,1.
REQ-025 Bench: SPI_CFG_ADDR_CHECK_EN defined, req0 addr=7'h05 -> req_ready pulse, err pulse next cycle, ncs never low; without the macro, the frame sends 8'h85 as its first byte.
REQ-026 Bench: rst_n=0 for one cycle at the 8th sclk rising edge -> next cycle ncs=1, sclk=0, busy=0, no done; a following request frames normally.
REQ-027 Bench: CLK_DIV=6 with the DUT driving the register-file SPI slave -> slave register 7'h03 reads 8'h3C after write data 8'h3C.

Source files
------------

// File: rtl/spi_cfg_master_if.sv
// Request bus and SPI pins of spi_cfg_master: two write requesters in, SPI mode-0 frame out.
interface spi_cfg_master_if;
  logic [1:0]  req_valid;
  logic [13:0] req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        sclk;
  logic        ncs;
  logic        copi;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  req_valid, req_addr, req_data,
    output req_ready, sclk, ncs, copi, busy, done, err
  );

  modport slave (
    output req_valid, req_addr, req_data,
    input  req_ready, sclk, ncs, copi, busy, done, err
  );
endinterface

// File: rtl/spi_cfg_master.sv
// Two-requester round-robin SPI (mode 0) register-write master: 16-bit frames {1, addr[6:0], data[7:0]}.
// Optional macro SPI_CFG_ADDR_CHECK_EN rejects addresses above MAX_ADDR with an err pulse.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [6:0]  MAX_ADDR   = 7'h04
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_cfg_master_if.master bus
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      r_state, w_state_nx;
  logic [7:0]  r_div, w_div_nx;
  logic [4:0]  r_bits, w_bits_nx;
  logic [15:0] r_frame, w_frame_nx;
  logic [1:0]  r_ready, w_ready_nx;
  logic        r_ptr, w_ptr_nx;
  logic        r_sclk, w_sclk_nx;
  logic        r_ncs, w_ncs_nx;
  logic        r_copi, w_copi_nx;
  logic        r_busy, w_busy_nx;
  logic        r_done, w_done_nx;
  logic        w_gnt;
  logic        w_grant;
  logic        w_reject;
  logic [6:0]  w_addr;
  logic [7:0]  w_data;

  // A lone request wins outright; with both pending the pointer decides.
  always_comb begin
    w_gnt = r_ptr;
    if (bus.req_valid == 2'b01) begin
      w_gnt = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      w_gnt = 1'b1;
    end else begin
      w_gnt = r_ptr;
    end
  end

  assign w_addr  = w_gnt ? bus.req_addr[13:7] : bus.req_addr[6:0];
  assign w_data  = w_gnt ? bus.req_data[15:8] : bus.req_data[7:0];
  assign w_grant = (r_state == ST_IDLE) && (r_ready == 2'b00) && (bus.req_valid != 2'b00);

`ifdef SPI_CFG_ADDR_CHECK_EN
  logic r_bad;
  logic r_err;

  // Flag an out-of-range grant; the rejection is reported the cycle after req_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_bad <= (w_addr > MAX_ADDR);
      end else begin
        r_bad <= r_bad;
      end
      r_err <= (r_state == ST_IDLE) && (r_ready != 2'b00) && r_bad;
    end
  end

  assign w_reject = r_bad;
  assign bus.err  = r_err;
`else
  assign w_reject = 1'b0;
  assign bus.err  = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_bits_nx  = r_bits;
    w_frame_nx = r_frame;
    w_ptr_nx   = r_ptr;
    w_ready_nx = 2'b00;
    w_sclk_nx  = 1'b0;
    w_ncs_nx   = 1'b1;
    w_copi_nx  = r_copi;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_copi_nx = 1'b0;
        if (r_ready != 2'b00) begin
          if (w_reject) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_SETUP;
            w_div_nx   = DIV_LOAD;
            w_bits_nx  = 5'd0;
            w_ncs_nx   = 1'b0;
            w_copi_nx  = r_frame[15];
          end
        end else if (w_grant) begin
          w_ready_nx = w_gnt ? 2'b10 : 2'b01;
          w_ptr_nx   = ~w_gnt;
          w_frame_nx = {1'b1, w_addr, w_data};
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_ncs_nx = 1'b0;
        if (r_div == 8'd0) begin
          w_state_nx = ST_SHIFT;
          w_div_nx   = DIV_LOAD;
          w_sclk_nx  = 1'b1;
          w_bits_nx  = 5'd1;
        end else begin
          w_div_nx = r_div - 8'd1;
        end
      end
      ST_SHIFT: begin
        w_ncs_nx  = 1'b0;
        w_sclk_nx = r_sclk;
        if (r_div != 8'd0) begin
          w_div_nx = r_div - 8'd1;
        end else if (r_sclk) begin
          // Falling edge: present the next bit so it is stable across the whole high phase.
          w_sclk_nx  = 1'b0;
          w_div_nx   = DIV_LOAD;
          w_frame_nx = {r_frame[14:0], 1'b0};
          w_copi_nx  = r_frame[14];
        end else if (r_bits == 5'd16) begin
          w_state_nx = ST_HOLD;
          w_div_nx   = DIV_LOAD;
        end else begin
          w_sclk_nx = 1'b1;
          w_div_nx  = DIV_LOAD;
          w_bits_nx = r_bits + 5'd1;
        end
      end
      ST_HOLD: begin
        w_ncs_nx = 1'b0;
        if (r_div == 8'd0) begin
          w_state_nx = ST_GAP;
          w_ncs_nx   = 1'b1;
          w_done_nx  = 1'b1;
          w_copi_nx  = 1'b0;
          w_div_nx   = GAP_LOAD;
        end else begin
          w_div_nx = r_div - 8'd1;
        end
      end
      ST_GAP: begin
        if (r_div == 8'd0) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_div_nx = r_div - 8'd1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_copi_nx  = 1'b0;
      end
    endcase
    w_busy_nx = (w_state_nx != ST_IDLE) || (w_ready_nx != 2'b00);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= 8'd0;
      r_bits  <= 5'd0;
      r_frame <= 16'h0000;
      r_ready <= 2'b00;
      r_ptr   <= 1'b0;
      r_sclk  <= 1'b0;
      r_ncs   <= 1'b1;
      r_copi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_bits  <= w_bits_nx;
      r_frame <= w_frame_nx;
      r_ready <= w_ready_nx;
      r_ptr   <= w_ptr_nx;
      r_sclk  <= w_sclk_nx;
      r_ncs   <= w_ncs_nx;
      r_copi  <= w_copi_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.sclk      = r_sclk;
  assign bus.ncs       = r_ncs;
  assign bus.copi      = r_copi;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: default-parameter instance plus a CLK_DIV=6 instance feeding a register-file SPI slave.
module tb_spi_cfg_master;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_cfg_master_if if0 ();
  spi_cfg_master_if if1 ();

  spi_cfg_master #(.CLK_DIV(4), .GAP_CYCLES(4), .MAX_ADDR(7'h04)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  spi_cfg_master #(.CLK_DIV(6), .GAP_CYCLES(4), .MAX_ADDR(7'h04)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int total = 0;
  int bad = 0;

  // Monitor state for dut0
  int cyc = 0;
  int ncs_low_run = 0, last_low_len = 0, gap_run = 0, last_gap_len = 0, ncs_low_total = 0;
  int done_cnt = 0, err_cnt = 0, copi_viol = 0, rise_cnt = 0, cap_bits = 0;
  int last_ready_cyc = -10, last_err_cyc = -20, done_cyc = 0, busy_fall_cyc = 0;
  int grants[$];
  logic [15:0] frame_q[$];
  logic [15:0] cap = 16'h0000;
  logic prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0, prev_busy = 1'b0;
  logic [1:0] hold_mask = 2'b00;
  logic repulse0 = 1'b0;

  // Slave model on dut1
  logic [7:0] slv_regs [0:127];
  logic [15:0] slv_sr = 16'h0000;
  int slv_bits = 0;
  int ncs1_low = 0;

  always @(negedge clk) begin
    cyc++;
    if (if0.req_ready[0] === 1'b1) begin grants.push_back(0); last_ready_cyc = cyc; end
    if (if0.req_ready[1] === 1'b1) begin grants.push_back(1); last_ready_cyc = cyc; end
    if (if0.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (if0.err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
    if (prev_busy === 1'b1 && if0.busy === 1'b0) busy_fall_cyc = cyc;
    if (if0.sclk === 1'b1 && prev_sclk === 1'b1 && if0.copi !== prev_copi) copi_viol++;
    if (if0.ncs === 1'b0) begin
      if (prev_ncs === 1'b1) begin last_gap_len = gap_run; cap = 16'h0000; cap_bits = 0; end
      ncs_low_run++;
      ncs_low_total++;
    end else begin
      if (prev_ncs === 1'b0) begin
        last_low_len = ncs_low_run;
        frame_q.push_back(cap);
        ncs_low_run = 0;
        gap_run = 0;
      end
      gap_run++;
    end
    prev_ncs = if0.ncs; prev_sclk = if0.sclk; prev_copi = if0.copi; prev_busy = if0.busy;
    if (if1.ncs === 1'b0) ncs1_low++;
  end

  always @(posedge if0.sclk) begin
    if (if0.ncs === 1'b0) begin cap = {cap[14:0], if0.copi}; cap_bits++; rise_cnt++; end
  end

  always @(posedge if1.sclk) begin
    if (if1.ncs === 1'b0) begin slv_sr = {slv_sr[14:0], if1.copi}; slv_bits++; end
  end
  always @(negedge if1.ncs) slv_bits = 0;
  always @(posedge if1.ncs) begin
    if (slv_bits == 16 && slv_sr[15] === 1'b1) slv_regs[slv_sr[14:8]] = slv_sr[7:0];
  end

  task automatic clear_mon();
    grants.delete(); frame_q.delete();
    done_cnt = 0; err_cnt = 0; copi_viol = 0; rise_cnt = 0; cap_bits = 0;
    last_low_len = 0; last_gap_len = 0; ncs_low_total = 0;
    last_ready_cyc = -10; last_err_cyc = -20; done_cyc = 0; busy_fall_cyc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  // One clock of the dut0 requesters: drop valid after handshake, optionally re-raise req0 in IDLE.
  task automatic step();
    logic [1:0] seen;
    @(negedge clk);
    seen = if0.req_ready;
    @(posedge clk); #1;
    if0.req_valid = if0.req_valid & ~(seen & ~hold_mask);
    if (repulse0 && if0.busy === 1'b0 && if0.req_valid[0] === 1'b0) if0.req_valid[0] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (if0.ncs !== 1'b1) begin bad++; $display("FAIL reset_ncs: got %b expected 1", if0.ncs); end
    total++; if (if0.sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b expected 0", if0.sclk); end
    total++; if (if0.copi !== 1'b0) begin bad++; $display("FAIL reset_copi: got %b expected 0", if0.copi); end
    total++; if (if0.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b expected 00", if0.req_ready); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", if0.busy); end
    total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", if0.done); end
    total++; if (if0.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", if0.err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_single_frame();
    do_reset();
    if0.req_addr = {7'h00, 7'h00}; if0.req_data = {8'h00, 8'hA5}; if0.req_valid = 2'b01;
    for (int i = 0; i < 400 && !(done_cnt >= 1 && if0.busy === 1'b0); i++) step();
    @(negedge clk); #1;
    total++; if (!(done_cnt >= 1 && if0.busy === 1'b0)) begin bad++; $display("FAIL single_timeout: done=%0d busy=%b", done_cnt, if0.busy); end
    total++; if (frame_q.size() != 1 || frame_q[0] !== 16'h80A5) begin bad++; $display("FAIL single_bits: got %h (n=%0d) expected 80a5", cap, frame_q.size()); end
    total++; if (cap_bits != 16) begin bad++; $display("FAIL single_edges: got %0d expected 16", cap_bits); end
    total++; if (last_low_len != 136) begin bad++; $display("FAIL single_ncs_low: got %0d expected 136", last_low_len); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done: got %0d expected 1", done_cnt); end
    total++; if (copi_viol != 0) begin bad++; $display("FAIL single_copi_stable: got %0d changes expected 0", copi_viol); end
    total++; if (busy_fall_cyc - done_cyc != 4) begin bad++; $display("FAIL single_gap_busy: got %0d expected 4", busy_fall_cyc - done_cyc); end
    total++; if (grants.size() != 1 || grants[0] != 0) begin bad++; $display("FAIL single_grant: got n=%0d expected one grant to 0", grants.size()); end
  endtask

  task automatic test_two_requesters();
    if0.req_addr = {7'h04, 7'h02}; if0.req_data = {8'h80, 8'h0F}; if0.req_valid = 2'b11;
    do_reset();
    for (int i = 0; i < 800 && done_cnt < 2; i++) step();
    for (int i = 0; i < 20 && if0.busy !== 1'b0; i++) step();
    total++; if (done_cnt != 2) begin bad++; $display("FAIL two_done: got %0d expected 2", done_cnt); end
    total++; if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin bad++; $display("FAIL two_order: got n=%0d expected 0 then 1", grants.size()); end
    total++; if (frame_q.size() != 2 || frame_q[0] !== 16'h820F) begin bad++; $display("FAIL two_frame0: got n=%0d expected 820f first", frame_q.size()); end
    total++; if (frame_q.size() != 2 || frame_q[1] !== 16'h8480) begin bad++; $display("FAIL two_frame1: got n=%0d expected 8480 second", frame_q.size()); end
    total++; if (last_gap_len < 4) begin bad++; $display("FAIL two_gap: got %0d expected >=4", last_gap_len); end
  endtask

  task automatic test_round_robin();
    do_reset();
    if0.req_addr = {7'h02, 7'h01}; if0.req_data = {8'h22, 8'h11};
    hold_mask = 2'b10; repulse0 = 1'b1; if0.req_valid = 2'b11;
    for (int i = 0; i < 1000 && grants.size() < 4; i++) step();
    hold_mask = 2'b00; repulse0 = 1'b0; if0.req_valid = 2'b00;
    for (int i = 0; i < 400 && !(done_cnt >= 4 && if0.busy === 1'b0); i++) step();
    total++; if (grants.size() != 4) begin bad++; $display("FAIL rr_count: got %0d expected 4", grants.size()); end
    else begin
      total++; if ({grants[0][0], grants[1][0], grants[2][0], grants[3][0]} !== 4'b0101) begin
        bad++; $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", grants[0], grants[1], grants[2], grants[3]);
      end
    end
    total++; if (frame_q.size() != 4 || frame_q[1] !== 16'h8222) begin bad++; $display("FAIL rr_frame1: got n=%0d expected 8222 second", frame_q.size()); end
  endtask

  task automatic test_addr_check();
    do_reset();
    if0.req_addr = {7'h00, 7'h05}; if0.req_data = {8'h00, 8'h11}; if0.req_valid = 2'b01;
`ifdef SPI_CFG_ADDR_CHECK_EN
    for (int i = 0; i < 40; i++) step();
    total++; if (grants.size() != 1) begin bad++; $display("FAIL chk_ready: got %0d grants expected 1", grants.size()); end
    total++; if (err_cnt != 1) begin bad++; $display("FAIL chk_err_count: got %0d expected 1", err_cnt); end
    total++; if (last_err_cyc != last_ready_cyc + 1) begin bad++; $display("FAIL chk_err_timing: got %0d expected %0d", last_err_cyc, last_ready_cyc + 1); end
    total++; if (ncs_low_total != 0) begin bad++; $display("FAIL chk_no_frame: got %0d ncs-low cycles expected 0", ncs_low_total); end
    if0.req_addr = {7'h01, 7'h00}; if0.req_data = {8'h02, 8'h01}; if0.req_valid = 2'b11;
    for (int i = 0; i < 50 && grants.size() < 2; i++) step();
    if0.req_valid = 2'b00;
    total++; if (grants.size() != 2 || grants[1] != 1) begin bad++; $display("FAIL chk_pointer: got n=%0d expected second grant to 1", grants.size()); end
    for (int i = 0; i < 400 && !(done_cnt >= 1 && if0.busy === 1'b0); i++) step();
`else
    for (int i = 0; i < 400 && !(done_cnt >= 1 && if0.busy === 1'b0); i++) step();
    total++; if (frame_q.size() != 1 || frame_q[0][15:8] !== 8'h85) begin bad++; $display("FAIL nochk_byte: got n=%0d expected first byte 85", frame_q.size()); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL nochk_err: got %0d expected 0", err_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL nochk_done: got %0d expected 1", done_cnt); end
`endif
  endtask

  task automatic test_reset_midframe();
    do_reset();
    if0.req_addr = {7'h00, 7'h01}; if0.req_data = {8'h00, 8'h5A}; if0.req_valid = 2'b01;
    for (int i = 0; i < 200 && rise_cnt < 8; i++) step();
    total++; if (rise_cnt != 8) begin bad++; $display("FAIL mid_reach8: got %0d edges expected 8", rise_cnt); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (if0.ncs !== 1'b1) begin bad++; $display("FAIL mid_ncs: got %b expected 1", if0.ncs); end
    total++; if (if0.sclk !== 1'b0) begin bad++; $display("FAIL mid_sclk: got %b expected 0", if0.sclk); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b expected 0", if0.busy); end
    for (int i = 0; i < 30; i++) step();
    total++; if (done_cnt != 0) begin bad++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt); end
    clear_mon();
    if0.req_valid = 2'b01;
    for (int i = 0; i < 400 && !(done_cnt >= 1 && if0.busy === 1'b0); i++) step();
    total++; if (frame_q.size() != 1 || frame_q[0] !== 16'h815A) begin bad++; $display("FAIL mid_refrane: got n=%0d expected 815a", frame_q.size()); end
    total++; if (last_low_len != 136) begin bad++; $display("FAIL mid_ncs_low: got %0d expected 136", last_low_len); end
  endtask

  task automatic if1_write(input logic idx, input logic [6:0] addr, input logic [7:0] data, output logic ok);
    logic seen_rdy;
    logic seen_done;
    seen_rdy = 1'b0; seen_done = 1'b0;
    if1.req_addr = {addr, addr}; if1.req_data = {data, data};
    if1.req_valid = idx ? 2'b10 : 2'b01;
    for (int i = 0; i < 600 && !seen_done; i++) begin
      @(negedge clk);
      if (if1.req_ready != 2'b00) seen_rdy = 1'b1;
      if (if1.done === 1'b1) seen_done = 1'b1;
      @(posedge clk); #1;
      if (seen_rdy) if1.req_valid = 2'b00;
    end
    repeat (6) @(posedge clk);
    #1;
    ok = seen_done;
  endtask

  task automatic test_slave_div6();
    logic ok;
    for (int i = 0; i < 128; i++) slv_regs[i] = 8'h00;
    do_reset();
    ncs1_low = 0;
    if1_write(1'b0, 7'h03, 8'h3C, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL div6_timeout: got done=%b expected 1", ok); end
    total++; if (slv_regs[3] !== 8'h3C) begin bad++; $display("FAIL div6_reg3: got %h expected 3c", slv_regs[3]); end
    total++; if (ncs1_low != 204) begin bad++; $display("FAIL div6_ncs_low: got %0d expected 204", ncs1_low); end
    if1_write(1'b1, 7'h01, 8'h96, ok);
    total++; if (slv_regs[1] !== 8'h96) begin bad++; $display("FAIL div6_reg1: got %h expected 96", slv_regs[1]); end
    total++; if (slv_regs[2] !== 8'h00) begin bad++; $display("FAIL div6_reg2: got %h expected 00", slv_regs[2]); end
  endtask

  initial begin
    rst_n = 1'b0;
    if0.req_valid = 2'b00; if0.req_addr = 14'h0000; if0.req_data = 16'h0000;
    if1.req_valid = 2'b00; if1.req_addr = 14'h0000; if1.req_data = 16'h0000;
    test_reset();
    test_single_frame();
    test_two_requesters();
    test_round_robin();
    test_addr_check();
    test_reset_midframe();
    test_slave_div6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
